// File: rtl/dct_block_sequencer_if.sv
// Handshake/bus bundle between the DCT block sequencer, the pixel buffer,
// the cosine LUT bank and the downstream quantizer.
interface dct_block_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        pix_rd_en;
  logic [5:0]  pix_addr;
  logic [7:0]  pix_rdata;
  logic [2:0]  lut_k1;
  logic [2:0]  lut_k2;
  logic [2:0]  lut_n1;
  logic [2:0]  lut_n2;
  logic [31:0] lut_cos;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] coef_data;
  logic [2:0]  coef_k1;
  logic [2:0]  coef_k2;

  modport master (
    input  start, pix_rdata, lut_cos, coef_ready,
    output busy, done, pix_rd_en, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
           coef_valid, coef_data, coef_k1, coef_k2
  );

  modport slave (
    output start, pix_rdata, lut_cos, coef_ready,
    input  busy, done, pix_rd_en, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2,
           coef_valid, coef_data, coef_k1, coef_k2
  );
endinterface

// File: rtl/dct_block_sequencer.sv
// Walks one 8x8 block through the cosine LUT and a single MAC, emitting
// 64 saturated coefficients in raster (k1,k2) order over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing pixel reads / LUT selects for (n1,n2) = 0..63
// DRAIN | last product lands in the accumulator
// OUT   | coefficient presented, waiting for coef_ready
module dct_block_sequencer #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 48
) (
  input logic                  clk,
  input logic                  reset,
  dct_block_sequencer_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t                   state_q, state_d;
  logic [2:0]               k1_q, k1_d, k2_q, k2_d, n1_q, n1_d, n2_q, n2_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [31:0]       cos_q, cos_d;
  logic                     issue_q, issue_d;
  logic                     done_q, done_d;
  logic signed [15:0]       coef_data_q, coef_data_d;
  logic [2:0]               coef_k1_q, coef_k1_d, coef_k2_q, coef_k2_d;

  logic signed [39:0]       pix_ext, cos_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_sum, shifted;
  logic signed [15:0]       sat_val;

  // MAC stage runs one cycle behind issue, matching the pixel read latency
  always_comb begin
    pix_ext  = {{32{bus.pix_rdata[7]}}, bus.pix_rdata};
    cos_ext  = {{8{cos_q[31]}}, cos_q};
    prod     = pix_ext * cos_ext;
    prod_ext = {{(ACC_W-40){prod[39]}}, prod};
    acc_sum  = issue_q ? acc_q + prod_ext : acc_q;
    shifted  = acc_sum >>> FRAC_BITS;
    if (shifted > SAT_MAX)      sat_val = 16'sh7FFF;
    else if (shifted < SAT_MIN) sat_val = 16'sh8000;
    else                        sat_val = shifted[15:0];
  end

  always_comb begin
    state_d     = state_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    n1_d        = n1_q;
    n2_d        = n2_q;
    acc_d       = acc_sum;
    cos_d       = cos_q;
    issue_d     = 1'b0;
    done_d      = 1'b0;
    coef_data_d = coef_data_q;
    coef_k1_d   = coef_k1_q;
    coef_k2_d   = coef_k2_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k1_d    = 3'd0;
          k2_d    = 3'd0;
          n1_d    = 3'd0;
          n2_d    = 3'd0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cos_d   = bus.lut_cos;
        issue_d = 1'b1;
        n2_d    = n2_q + 3'd1;
        if (n2_q == 3'd7) n1_d = n1_q + 3'd1;
        if (n1_q == 3'd7 && n2_q == 3'd7) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        coef_data_d = sat_val;
        coef_k1_d   = k1_q;
        coef_k2_d   = k2_q;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.coef_ready) begin
          acc_d = '0;
          n1_d  = 3'd0;
          n2_d  = 3'd0;
          k2_d  = k2_q + 3'd1;
          if (k2_q == 3'd7) k1_d = k1_q + 3'd1;
          if (k1_q == 3'd7 && k2_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k1_q        <= 3'd0;
      k2_q        <= 3'd0;
      n1_q        <= 3'd0;
      n2_q        <= 3'd0;
      acc_q       <= '0;
      cos_q       <= '0;
      issue_q     <= 1'b0;
      done_q      <= 1'b0;
      coef_data_q <= '0;
      coef_k1_q   <= 3'd0;
      coef_k2_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      acc_q       <= acc_d;
      cos_q       <= cos_d;
      issue_q     <= issue_d;
      done_q      <= done_d;
      coef_data_q <= coef_data_d;
      coef_k1_q   <= coef_k1_d;
      coef_k2_q   <= coef_k2_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.pix_rd_en  = (state_q == S_RUN);
  assign bus.pix_addr   = {n1_q, n2_q};
  assign bus.lut_k1     = k1_q;
  assign bus.lut_k2     = k2_q;
  assign bus.lut_n1     = n1_q;
  assign bus.lut_n2     = n2_q;
  assign bus.coef_valid = (state_q == S_OUT);
  assign bus.coef_data  = coef_data_q;
  assign bus.coef_k1    = coef_k1_q;
  assign bus.coef_k2    = coef_k2_q;
endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer: pixel buffer and LUT models,
// golden 2-D DCT sum, back-pressure, start glitches and mid-block reset.
module tb_dct_block_sequencer;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lut_mode = 1'b0;

  logic signed [7:0]  pix_mem [64];
  logic signed [15:0] got_data [64];
  logic [2:0]         got_k1 [64];
  logic [2:0]         got_k2 [64];
  logic signed [15:0] ref_data [64];

  // Q8 1-D cosine table, COS[k][n] ~ 256*cos((2n+1)k*pi/16)
  localparam int COS [8][8] = '{
    '{256, 256, 256, 256, 256, 256, 256, 256},
    '{251, 213, 142, 50, -50, -142, -213, -251},
    '{236, 98, -98, -236, -236, -98, 98, 236},
    '{213, -50, -251, -142, 142, 251, 50, -213},
    '{181, -181, -181, 181, 181, -181, -181, 181},
    '{142, -251, 50, 213, -213, -50, 251, -142},
    '{98, -236, 236, -98, -98, 236, -236, 98},
    '{50, -142, 213, -251, 251, -213, 142, -50}
  };

  dct_block_sequencer_if ifc ();

  dct_block_sequencer #(.FRAC_BITS(8), .ACC_W(48)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint lut_val(int k1, int k2, int n1, int n2);
    if (lut_mode) return 64'sd2147483647;
    return longint'((COS[k1][n1] * COS[k2][n2]) >>> 8);
  endfunction

  always_comb
    ifc.lut_cos = 32'(lut_val(int'(ifc.lut_k1), int'(ifc.lut_k2),
                              int'(ifc.lut_n1), int'(ifc.lut_n2)));

  always @(posedge clk)
    if (ifc.pix_rd_en) ifc.pix_rdata <= pix_mem[ifc.pix_addr];

  function automatic longint golden(int k1, int k2);
    longint acc = 0;
    for (int n = 0; n < 64; n++)
      acc += longint'(pix_mem[n]) * lut_val(k1, k2, n / 8, n % 8);
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, ifc.busy, 0);
    check({pfx, "_done"}, ifc.done, 0);
    check({pfx, "_coef_valid"}, ifc.coef_valid, 0);
    check({pfx, "_coef_data"}, $signed(ifc.coef_data), 0);
    check({pfx, "_coef_k"}, {ifc.coef_k1, ifc.coef_k2}, 0);
    check({pfx, "_pix_rd_en"}, ifc.pix_rd_en, 0);
    check({pfx, "_pix_addr"}, ifc.pix_addr, 0);
    check({pfx, "_lut_sel"}, {ifc.lut_k1, ifc.lut_k2, ifc.lut_n1, ifc.lut_n2}, 0);
  endtask

  // Runs one block; optional stall index, start glitches, or abort index.
  task automatic run_block(input int stall_idx, input bit glitch, input int abort_idx);
    int t0;
    int w;
    int vcnt;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    t0 = cyc;
    check("busy_after_start", ifc.busy, 1);
    check("first_read", ifc.pix_rd_en, 1);
    for (int idx = 0; idx < 64; idx++) begin
      w = 0;
      while (!ifc.coef_valid && w < 200) begin
        if (abort_idx == idx && w == 10) begin
          check("abort_in_run", ifc.pix_rd_en, 1);
          reset = 1'b1;
          tick();
          check_reset_outputs("abort");
          reset = 1'b0;
          vcnt = 0;
          for (int i = 0; i < 100; i++) begin
            tick();
            if (ifc.coef_valid || ifc.busy) vcnt++;
          end
          check("abort_no_valid", vcnt, 0);
          return;
        end
        if (glitch && idx == 3 && w == 5) ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        w++;
      end
      check($sformatf("coef_valid_wait_%0d", idx), ifc.coef_valid, 1);
      if (!ifc.coef_valid) return;
      got_data[idx] = $signed(ifc.coef_data);
      got_k1[idx]   = ifc.coef_k1;
      got_k2[idx]   = ifc.coef_k2;
      if (idx == stall_idx) begin
        ifc.coef_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick();
          check("stall_valid", ifc.coef_valid, 1);
          check("stall_data", $signed(ifc.coef_data), got_data[idx]);
          check("stall_k", {ifc.coef_k1, ifc.coef_k2}, {got_k1[idx], got_k2[idx]});
          check("stall_no_read", ifc.pix_rd_en, 0);
        end
        ifc.coef_ready = 1'b1;
      end
      if (glitch && idx == 2) ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      if (idx == stall_idx) begin
        check("restart_rd_en", ifc.pix_rd_en, 1);
        check("restart_addr", ifc.pix_addr, 0);
      end
      if (idx == 63) begin
        check("done_pulse", ifc.done, 1);
        check("busy_at_done", ifc.busy, 0);
        check("done_latency", cyc - t0, 4224 + (stall_idx >= 0 ? 10 : 0));
        tick();
        check("done_one_cycle", ifc.done, 0);
      end
    end
  endtask

  task automatic check_block(input string tag);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s_k_%0d", tag, i), {got_k1[i], got_k2[i]}, i);
      check($sformatf("%s_data_%0d", tag, i), got_data[i], golden(i / 8, i % 8));
    end
  endtask

  initial begin
    reset          = 1'b1;
    ifc.start      = 1'b0;
    ifc.coef_ready = 1'b1;
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'sd0;
    @(negedge clk);
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();
    check_reset_outputs("idle");

    // all-zero pixels, reference LUT
    run_block(-1, 1'b0, -1);
    check_block("zero");
    for (int i = 0; i < 64; i++) check("zero_const", got_data[i], 0);

    // all-ones pixels
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'sd1;
    run_block(-1, 1'b0, -1);
    check("ones_dc", got_data[0], 64);
    check("ones_k02", got_data[2], 0);
    check_block("ones");

    // saturation with stub LUT
    lut_mode = 1'b1;
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'sd127;
    run_block(-1, 1'b0, -1);
    for (int i = 0; i < 64; i++) check("sat_pos", got_data[i], 32767);
    for (int i = 0; i < 64; i++) pix_mem[i] = -8'sd128;
    run_block(-1, 1'b0, -1);
    for (int i = 0; i < 64; i++) check("sat_neg", got_data[i], -32768);
    lut_mode = 1'b0;

    // mixed pattern with back-pressure on coefficient 5
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'(i * 37 + 11);
    run_block(5, 1'b0, -1);
    check_block("stall");
    for (int i = 0; i < 64; i++) ref_data[i] = got_data[i];

    // start glitches in RUN and OUT must not disturb the sequence
    run_block(-1, 1'b1, -1);
    for (int i = 0; i < 64; i++) check("glitch_same", got_data[i], ref_data[i]);

    // reset in the middle of coefficient 20, then a fresh block
    run_block(-1, 1'b0, 20);
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'(i * 5 - 100);
    run_block(-1, 1'b0, -1);
    check_block("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Sequences one 8x8 two-dimensional DCT block through the shared cosine-LUT bank and a single multiply-accumulate datapath. For each output coefficient (k1,k2), it walks all 64 spatial indices (n1,n2), drives the LUT select lines and the pixel buffer read port, accumulates pixel × cos_term, then emits one coefficient over a valid/ready handshake. It sits between the block pixel buffer and the downstream quantizer; alpha(k1)·alpha(k2) normalization is applied downstream.

## Interface
Parameters:
- FRAC_BITS, 8, fractional bits of lut_cos (Q8); accumulator arithmetic-shifted right by this before output.
- ACC_W, 48, signed accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin one block; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle after the last handshake.
- done  out  1  one-cycle pulse after the 64th coefficient handshake.
- pix_rd_en  out  1  pixel buffer read enable.
- pix_addr  out  6  {n1,n2}, row-major.
- pix_rdata  in  8  signed level-shifted pixel; valid exactly 1 cycle after pix_rd_en.
- lut_k1, lut_k2, lut_n1, lut_n2  out  3 each  LUT bank select.
- lut_cos  in  32  signed combinational LUT output for the current select.
- coef_valid  out  1  coefficient available.
- coef_ready  in  1  downstream accepts.
- coef_data  out  16  signed, saturated coefficient.
- coef_k1, coef_k2  out  3 each  index of coef_data.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE: if start, clear k1=k2=n1=n2=0, clear acc, go to RUN. Start in any other state is ignored.
- RUN: each cycle, pix_rd_en=1, pix_addr={n1,n2}, lut_*={k1,k2,n1,n2}. Register lut_cos into cos_q and set a 1-bit issue-valid flag. The (n1,n2) counter increments n2-fastest. After issuing (7,7), go to DRAIN.
- MAC stage, one cycle behind issue: when the delayed flag is set, acc += sign_extend(pix_rdata) × cos_q. The product is 40-bit signed, sign-extended to ACC_W.
- DRAIN: pix_rd_en=0. The last product is accumulated. Go to OUT.
- OUT: coef_valid=1. coef_data = sat16(acc >>> FRAC_BITS), arithmetic shift with truncation, clamped to [-32768, 32767]. coef_k1/coef_k2 = current k.
  - On valid&&ready: clear acc and n.
  - If k=(7,7), pulse done and go to IDLE.
  - Otherwise advance k (k2-fastest) and go to RUN.
- Coefficients are emitted in raster order of (k1,k2), 64 per block.
- coef_data and coef_k* are registered and held stable while coef_valid && !coef_ready.
- reset in any state: return to IDLE on the next edge and abandon the block. No partial coefficient is emitted.

## Timing
- Reset values:
  - busy=0, done=0, coef_valid=0, coef_data=0, coef_k1=coef_k2=0.
  - pix_rd_en=0, pix_addr=0, lut_*=0.
  - acc=0, all counters 0.
- Start accepted at edge T; first read is issued in cycle T+1.
- Per coefficient: 64 RUN cycles + 1 DRAIN cycle + ≥1 OUT cycle, so 66 cycles with coef_ready tied high.
- Full block with ready tied high: 64 × 66 = 4224 cycles from the first RUN cycle to done.
- done is asserted in the cycle following the final handshake. busy deasserts in the same cycle.
- Back-pressure stalls only in OUT. No reads are issued while waiting.

## Test plan
- All-zero pixels, behavioural LUT model, ready high:
  - 64 coefficients, all 0, in raster k order.
  - done exactly 4224 cycles after the first read.
- All pixels = 1, reference cosine table:
  - (0,0) gives 64, since cos_term = 256 everywhere.
  - (0,2) gives 0, since each row sums 236+98−98−236−236−98+98+236 = 0.
  - Remaining coefficients match the bench golden model bit-exactly.
- Saturation, stub LUT returns 0x7FFF_FFFF:
  - Pixels 127 → every coef_data = 32767.
  - Pixels −128 → every coef_data = −32768.
- Back-pressure: hold coef_ready low for 10 cycles on coefficient 5.
  - coef_valid, coef_data and coef_k* stay constant.
  - No pix_rd_en while waiting.
  - The next coefficient starts on the cycle after the handshake.
- start pulsed during RUN and OUT: ignored. Output sequence is identical to the undisturbed run.
- reset asserted mid-RUN of coefficient 20:
  - All outputs return to their reset values next cycle. No coef_valid until a new start.
  - A fresh block then produces correct results from (0,0).
